wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Result-side counterpart of the ALU operand selector.
- Takes one executed instruction (ALU result, PC, destination, writeback select) through a valid/ready handshake.
- For loads, issues a data-memory read and waits for the response, then aligns and extends the load data.
- Selects the final writeback value and drives the register-file write port for exactly one cycle per instruction.

Parameters:
- PC_STEP, 4, increment added to PC for the link value (JAL/JALR writeback).
- ADDR_W, 32, memory address width; equals datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  unit can accept; high only in IDLE.
- alu_res  in  32  ALU result; this is the effective address for loads.
- pc  in  32  PC of the instruction.
- wb_sel  in  2  writeback source: 00 ALU, 01 MEM, 10 PC+PC_STEP, 11 no write.
- rd  in  5  destination register index.
- funct3  in  3  load width/sign (RV32I encoding).
- mem_req_valid  out  1  read request valid.
- mem_req_addr  out  ADDR_W  read address (full byte address).
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  read data valid.
- mem_resp_data  in  32  aligned 32-bit word containing the target bytes.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write index.
- rf_wdata  out  32  register-file write data.
- done  out  1  one-cycle retire pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: FSM in IDLE; all latched fields and rf_wdata/rf_waddr = 0; mem_req_valid = rf_we = done = 0; in_ready = 1 once rst deasserts.
- States: IDLE, REQ, RESP, WB. All outputs decode from state plus latched registers; there is no combinational path from any input to any output.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch alu_res, pc, wb_sel, rd, funct3.
  - If wb_sel = 01, go to REQ.
  - Otherwise compute the result into the data register (ALU, or pc+PC_STEP mod 2^32) and go to WB.
- REQ:
  - mem_req_valid = 1; mem_req_addr = latched alu_res. Both held stable until mem_req_ready.
  - On mem_req_ready, go to RESP.
- RESP:
  - Wait for mem_resp_valid. Capture aligned/extended data, then go to WB.
  - mem_resp_valid is ignored in every other state.
  - Responder guarantees the response comes no earlier than the cycle after request acceptance.
- WB:
  - done = 1.
  - rf_we = 1 unless wb_sel = 11 or rd = 0.
  - rf_waddr = rd; rf_wdata = result.
  - Next state IDLE unconditionally.
- Load alignment: off = addr[1:0].
  - 000 LB: byte at bit off*8, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at bit addr[1]*16, sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word.
  - Any other funct3: treated as LW.
  - addr[0] = 1 on a halfword access: addr[0] is ignored; no trap is raised.
- Latency:
  - Non-load: accepted at cycle t, rf_we at t+1, in_ready back at t+2.
  - Load with zero-wait memory: accept t, REQ t+1 (ready), RESP t+2 (resp_valid), WB t+3.
- Throughput: at most one instruction in flight; there is no back-to-back acceptance (in_ready = 0 in WB).
- Reset mid-operation: immediately returns to IDLE and drops mem_req_valid/rf_we. A late mem_resp_valid after reset produces no write.
- wb_sel/funct3 are only sampled at acceptance; later input changes have no effect.

Test Plan:
- ALU writeback: rd=5, wb_sel=00, alu_res=0x1234_5678 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678, done=1; then in_ready=1.
- Link: wb_sel=10, pc=0x8000_0FFC -> rf_wdata=0x8000_1000. Repeat with pc=0xFFFF_FFFC -> rf_wdata=0x0000_0000.
- Loads from word 0x80FF_7F01:
  - LB, addr ending 2'b10 -> rf_wdata=0xFFFF_FFFF.
  - LBU, addr ending 2'b01 -> rf_wdata=0x0000_007F.
  - LH, addr[1]=1 -> rf_wdata=0xFFFF_80FF.
  - LHU, addr[1]=0 -> rf_wdata=0x0000_7F01.
- Backpressure: hold mem_req_ready=0 for 3 cycles -> mem_req_valid stays 1 and mem_req_addr stays constant. Then response after 2 idle cycles -> exactly one rf_we pulse.
- No-write cases:
  - wb_sel=11 -> done=1, rf_we=0.
  - rd=0 with wb_sel=00 -> done=1, rf_we=0.
- Reset in RESP: assert rst while waiting, then drive mem_resp_valid after release -> no rf_we, state IDLE, in_ready=1.

Source files
------------

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback unit: load request/response handling, load alignment, register-file write
// One instruction in flight; outputs are registered from the next-state decode.
module wb_unit #(
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       pc,
  input  logic [1:0]        wb_sel,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic        rf_we_q, rf_we_d;
  logic        done_q, done_d;

  function automatic logic [31:0] load_align(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    // Halfword select uses addr[1] only; a misaligned addr[0] is silently dropped.
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_align = {{24{b[7]}}, b};
      3'b100:  load_align = {24'b0, b};
      3'b001:  load_align = {{16{h[15]}}, h};
      3'b101:  load_align = {16'b0, h};
      default: load_align = word;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    pc_d     = pc_q;
    data_d   = data_q;
    wb_sel_d = wb_sel_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          alu_d    = alu_res;
          pc_d     = pc;
          wb_sel_d = wb_sel;
          rd_d     = rd;
          funct3_d = funct3;
          if (wb_sel == 2'b01) begin
            state_d = S_REQ;
          end else begin
            data_d  = (wb_sel == 2'b10) ? pc + 32'(PC_STEP) : alu_res;
            state_d = S_WB;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          data_d  = load_align(mem_resp_data, alu_q[1:0], funct3_q);
          state_d = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d      = (state_d == S_IDLE);
    mem_req_valid_d = (state_d == S_REQ);
    done_d          = (state_d == S_WB);
    rf_we_d         = (state_d == S_WB) && (wb_sel_d != 2'b11) && (rd_d != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      alu_q           <= '0;
      pc_q            <= '0;
      data_q          <= '0;
      wb_sel_q        <= '0;
      rd_q            <= '0;
      funct3_q        <= '0;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      rf_we_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      alu_q           <= alu_d;
      pc_q            <= pc_d;
      data_q          <= data_d;
      wb_sel_q        <= wb_sel_d;
      rd_q            <= rd_d;
      funct3_q        <= funct3_d;
      in_ready_q      <= in_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      rf_we_q         <= rf_we_d;
      done_q          <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = alu_q[ADDR_W-1:0];
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rd_q;
  assign rf_wdata      = data_q;
  assign done          = done_q;

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - self-checking bench for wb_unit with a writeback scoreboard
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] alu_res, pc;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_resp_data;
  logic        rf_we, done;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_unit #(.PC_STEP(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .pc(pc), .wb_sel(wb_sel), .rd(rd), .funct3(funct3),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Present one instruction for exactly one accepting edge, then scramble the inputs.
  task automatic issue(input logic [1:0] ws, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] p, input logic [2:0] f3);
    in_valid = 1'b1; wb_sel = ws; rd = r; alu_res = a; pc = p; funct3 = f3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wb_sel = 2'($urandom); rd = 5'($urandom); alu_res = $urandom; pc = $urandom; funct3 = 3'($urandom);
  endtask

  // Play the memory side until done is seen or the cycle budget runs out.
  task automatic wait_done(input int stall, input int gap, input logic [31:0] word,
                           output bit seen, output int hold_err, output int stall_cycles);
    int          phase = 0;
    bit          have_addr = 0;
    logic [31:0] addr0 = '0;
    seen = 0; hold_err = 0; stall_cycles = 0;
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1) begin
        seen = 1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        break;
      end
      case (phase)
        0: if (mem_req_valid === 1'b1) begin
             if (!have_addr) begin addr0 = mem_req_addr; have_addr = 1; end
             else if (mem_req_addr !== addr0) hold_err++;
             if (stall > 0) begin mem_req_ready = 1'b0; stall--; stall_cycles++; end
             else begin mem_req_ready = 1'b1; phase = 1; end
           end
        1: begin
             mem_req_ready = 1'b0;
             if (gap > 0) gap--;
             else begin mem_resp_valid = 1'b1; mem_resp_data = word; phase = 2; end
           end
        default: mem_resp_valid = 1'b0;
      endcase
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if ({mem_req_valid, rf_we, done} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b want=000", {mem_req_valid, rf_we, done}); end
    total++; if (rf_wdata !== 32'h0 || rf_waddr !== 5'h0) begin bad++; $display("FAIL reset_rf got=%h/%0d want=0/0", rf_wdata, rf_waddr); end
  endtask

  task automatic test_alu;
    bit seen; int he, sc; exp_t e;
    sb.push_back('{1'b1, 5'd5, 32'h1234_5678, 1'b1});
    issue(2'b00, 5'd5, 32'h1234_5678, 32'h0000_0100, 3'b010);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL alu_latency done got=%b want=1", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL alu_in_ready_wb got=%b want=0", in_ready); end
    wait_done(0, 0, 32'h0, seen, he, sc);
    e = sb.pop_front();
    total++;
    if (!seen) begin bad++; $display("FAIL alu_timeout done got=%b want=1", done); end
    else if (rf_we !== e.we || rf_waddr !== e.waddr || rf_wdata !== e.wdata) begin
      bad++; $display("FAIL alu_wb got=%b/%0d/%h want=%b/%0d/%h", rf_we, rf_waddr, rf_wdata, e.we, e.waddr, e.wdata);
    end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL alu_return got=%b%b want=10", in_ready, done); end
  endtask

  task automatic test_link;
    logic [31:0] pcs [2];
    bit seen; int he, sc; exp_t e;
    pcs[0] = 32'h8000_0FFC; pcs[1] = 32'hFFFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, 5'(i + 1), pcs[i] + 32'd4, 1'b1});
      issue(2'b10, 5'(i + 1), 32'hAAAA_5555, pcs[i], 3'b000);
      wait_done(0, 0, 32'h0, seen, he, sc);
      e = sb.pop_front();
      total++;
      if (!seen) begin bad++; $display("FAIL link%0d_timeout done got=%b want=1", i, done); end
      else if (rf_we !== e.we || rf_waddr !== e.waddr || rf_wdata !== e.wdata) begin
        bad++; $display("FAIL link%0d got=%b/%0d/%h want=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, e.we, e.waddr, e.wdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [8];
    logic [1:0]  offs [8];
    logic [31:0] exps [8];
    bit seen; int he, sc; exp_t e;
    f3s[0] = 3'b000; offs[0] = 2'd2; exps[0] = 32'hFFFF_FFFF;
    f3s[1] = 3'b100; offs[1] = 2'd1; exps[1] = 32'h0000_007F;
    f3s[2] = 3'b001; offs[2] = 2'd2; exps[2] = 32'hFFFF_80FF;
    f3s[3] = 3'b101; offs[3] = 2'd0; exps[3] = 32'h0000_7F01;
    f3s[4] = 3'b010; offs[4] = 2'd0; exps[4] = 32'h80FF_7F01;
    f3s[5] = 3'b001; offs[5] = 2'd3; exps[5] = 32'hFFFF_80FF;
    f3s[6] = 3'b000; offs[6] = 2'd3; exps[6] = 32'hFFFF_FF80;
    f3s[7] = 3'b011; offs[7] = 2'd1; exps[7] = 32'h80FF_7F01;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{1'b1, 5'(10 + i), exps[i], 1'b1});
      issue(2'b01, 5'(10 + i), {28'h1000_000, 2'b00, offs[i]}, 32'h0, f3s[i]);
      total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== {28'h1000_000, 2'b00, offs[i]}) begin
        bad++; $display("FAIL load%0d_req got=%b/%h want=1/%h", i, mem_req_valid, mem_req_addr, {28'h1000_000, 2'b00, offs[i]});
      end
      wait_done(0, 0, 32'h80FF_7F01, seen, he, sc);
      e = sb.pop_front();
      total++;
      if (!seen) begin bad++; $display("FAIL load%0d_timeout done got=%b want=1", i, done); end
      else if (rf_we !== e.we || rf_waddr !== e.waddr || rf_wdata !== e.wdata) begin
        bad++; $display("FAIL load%0d got=%b/%0d/%h want=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, e.we, e.waddr, e.wdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    bit seen; int he, sc; exp_t e;
    sb.push_back('{1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1});
    issue(2'b01, 5'd7, 32'h2000_0004, 32'h0, 3'b010);
    wait_done(3, 2, 32'hDEAD_BEEF, seen, he, sc);
    total++; if (he !== 0 || sc !== 3) begin bad++; $display("FAIL bp_hold addr_changes=%0d stalls=%0d want 0/3", he, sc); end
    e = sb.pop_front();
    total++;
    if (!seen) begin bad++; $display("FAIL bp_timeout done got=%b want=1", done); end
    else if (rf_we !== e.we || rf_waddr !== e.waddr || rf_wdata !== e.wdata) begin
      bad++; $display("FAIL bp_wb got=%b/%0d/%h want=%b/%0d/%h", rf_we, rf_waddr, rf_wdata, e.we, e.waddr, e.wdata);
    end
    @(posedge clk); #1;
    total++; if (rf_we !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL bp_single_pulse got=%b%b want=00", rf_we, done); end
  endtask

  task automatic test_nowrite;
    bit seen; int he, sc; exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, (i == 0) ? 5'd9 : 5'd0, 32'h0, 1'b0});
      issue((i == 0) ? 2'b11 : 2'b00, (i == 0) ? 5'd9 : 5'd0, 32'hCAFE_F00D, 32'h0, 3'b010);
      wait_done(0, 0, 32'h0, seen, he, sc);
      e = sb.pop_front();
      total++;
      if (!seen) begin bad++; $display("FAIL nowrite%0d_timeout done got=%b want=1", i, done); end
      else if (rf_we !== e.we || rf_waddr !== e.waddr) begin
        bad++; $display("FAIL nowrite%0d got=%b/%0d want=%b/%0d", i, rf_we, rf_waddr, e.we, e.waddr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_resp;
    int writes = 0;
    issue(2'b01, 5'd3, 32'h0000_0040, 32'h0, 3'b010);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (mem_req_valid !== 1'b0 || rf_we !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid got=%b%b%b want=001", mem_req_valid, rf_we, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (rf_we === 1'b1 || done === 1'b1) writes++;
      @(posedge clk); #1;
    end
    total++; if (writes !== 0) begin bad++; $display("FAIL rst_late_resp writes got=%0d want=0", writes); end
    total++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b%b want=10", in_ready, mem_req_valid); end
  endtask

  initial begin
    in_valid = 1'b0; alu_res = '0; pc = '0; wb_sel = '0; rd = '0; funct3 = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    test_reset;
    test_alu;
    test_link;
    test_loads;
    test_backpressure;
    test_nowrite;
    test_reset_resp;
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
